// File: rtl/dram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dram_arbiter_pkg
// Shared definitions for the two-master data-RAM arbiter:
//   - arb_state_e     : arbitration FSM states (idle / owned by m0 / owned by m1)
//   - DATA_W          : data-path width of masters and RAM
//   - M0_IDX / M1_IDX : master index constants used for vector bit selects
//   - is_word_aligned : true when a byte address selects a whole 32-bit word
//   - own_state       : maps a master index to its ownership state
// -----------------------------------------------------------------------------
package dram_arbiter_pkg;

    localparam int DATA_W = 32;

    // Master 0 is the CPU, master 1 the debug loader.
    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    // A byte address is usable by the RAM only when it points at a word boundary.
    function automatic logic is_word_aligned(input logic [1:0] byte_lsb);
        return (byte_lsb == 2'b00);
    endfunction

    function automatic arb_state_e own_state(input logic idx);
        return (idx == M1_IDX) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/dram_arbiter_arb_rr_lock.sv
// -----------------------------------------------------------------------------
// arb_rr_lock
// Round-robin arbiter for two masters with optional exclusive lock.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   reqs   : request vector, bit i = master i
//   locks  : lock request vector, bit i = master i
//   grant  : combinational grant vector (never set without matching request,
//            forced to zero while rst is high)
//   owner  : index of the master the data path must be steered to this cycle
//
// In idle a lone requester wins; on a tie the master that was not granted
// last wins. An accepted locked access moves the FSM into ownership, where
// only the owner can be granted. Ownership ends when the owner drops its
// lock, or is forcibly revoked after MAX_LOCK cycles; a revoked master is
// blocked from re-locking until it drops its lock line once.
// -----------------------------------------------------------------------------
module arb_rr_lock
    import dram_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] reqs,
    input  logic [1:0] locks,
    output logic [1:0] grant,
    output logic       owner
);

    localparam int               CNT_W    = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

    arb_state_e       state_r;
    arb_state_e       state_nxt_s;
    logic             last_r;
    logic             last_nxt_s;
    logic [1:0]       blocked_r;
    logic [1:0]       blocked_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       grant_s;
    logic             sel_s;
    logic             own_idx_s;

    // State register: FSM state, round-robin pointer, lock blocks and hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            last_r    <= M1_IDX;
            blocked_r <= 2'b00;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            last_r    <= last_nxt_s;
            blocked_r <= blocked_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

    // Next-state and grant decode.
    always_comb begin
        grant_s     = 2'b00;
        sel_s       = last_r;
        own_idx_s   = M0_IDX;
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = cnt_r;
        // A block lasts only until the blocked master releases its lock line.
        blocked_nxt_s = blocked_r & locks;

        case (state_r)
            ST_IDLE: begin
                if (reqs == 2'b11) begin
                    sel_s   = ~last_r;
                    grant_s = (last_r == M1_IDX) ? 2'b01 : 2'b10;
                end else if (reqs[M0_IDX]) begin
                    sel_s   = M0_IDX;
                    grant_s = 2'b01;
                end else if (reqs[M1_IDX]) begin
                    sel_s   = M1_IDX;
                    grant_s = 2'b10;
                end else begin
                    sel_s   = last_r;
                    grant_s = 2'b00;
                end

                if (grant_s != 2'b00) begin
                    last_nxt_s = sel_s;
                    if (locks[sel_s] && !blocked_r[sel_s]) begin
                        state_nxt_s = own_state(sel_s);
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    last_nxt_s  = last_r;
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_OWN0, ST_OWN1: begin
                own_idx_s          = (state_r == ST_OWN1) ? M1_IDX : M0_IDX;
                sel_s              = own_idx_s;
                grant_s[own_idx_s] = reqs[own_idx_s];
                cnt_nxt_s          = cnt_r + CNT_W'(1);

                if (reqs[own_idx_s]) begin
                    last_nxt_s = own_idx_s;
                end else begin
                    last_nxt_s = last_r;
                end

                if (!locks[own_idx_s]) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    // Forced release: the other master gets the next tie.
                    state_nxt_s              = ST_IDLE;
                    blocked_nxt_s[own_idx_s] = 1'b1;
                    last_nxt_s               = own_idx_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end

            default: begin
                grant_s     = 2'b00;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // No access may be accepted while the arbiter is being reset.
    assign grant = rst ? 2'b00 : grant_s;
    assign owner = sel_s;

endmodule

// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
// Shares one single-port data RAM between the CPU (m0) and the debug loader
// (m1).
//   Parameters : MEM_AW   word-address width of the RAM
//                MAX_LOCK longest run of cycles one master may hold a lock
//   Clock/reset: clk_i, rst_i (synchronous, active high)
//   Masters    : mX_req_i/we_i/lock_i/addr_i/wdata_i in;
//                mX_gnt_o (combinational), mX_rvalid_o/rdata_o/err_o out
//   RAM side   : mem_addr_o/mem_we_o/mem_wdata_o out, mem_rdata_i in
//                (read data arrives the cycle after the address)
//
// Arbitration lives in arb_rr_lock. This level steers the accepted master's
// address/data to the RAM and routes the one-cycle-late response back. Read
// data is passed straight through from the RAM in the response cycle so that
// back-to-back reads stream one per cycle. Misaligned accesses never reach
// the RAM as writes and are answered with an error pulse (reads also get a
// zero-data rvalid).
// -----------------------------------------------------------------------------
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int MEM_AW   = 14,
    parameter int MAX_LOCK = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic              m0_lock_i,
    input  logic [31:0]       m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic              m1_lock_i,
    input  logic [31:0]       m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,

    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    logic [1:0]        gnt_s;
    logic              sel_s;
    logic              accept_s;
    logic              sel_we_s;
    logic [31:0]       sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              aligned_s;

    logic [MEM_AW-1:0] addr_hold_r;
    logic [DATA_W-1:0] wdata_hold_r;
    logic [1:0]        rvalid_r;
    logic [1:0]        err_r;
    logic [1:0]        rvalid_s;
    logic [1:0]        err_s;

    // Byte-address bits above the RAM window are intentionally ignored.
    logic              unused_addr_s;

    arb_rr_lock #(
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .clk   (clk_i),
        .rst   (rst_i),
        .reqs  ({m1_req_i, m0_req_i}),
        .locks ({m1_lock_i, m0_lock_i}),
        .grant (gnt_s),
        .owner (sel_s)
    );

    assign m0_gnt_o = gnt_s[M0_IDX];
    assign m1_gnt_o = gnt_s[M1_IDX];
    assign accept_s = |gnt_s;

    // Request mux: steer the selected master onto the shared path.
    always_comb begin
        if (sel_s == M1_IDX) begin
            sel_we_s    = m1_we_i;
            sel_addr_s  = m1_addr_i;
            sel_wdata_s = m1_wdata_i;
        end else begin
            sel_we_s    = m0_we_i;
            sel_addr_s  = m0_addr_i;
            sel_wdata_s = m0_wdata_i;
        end
    end

    assign aligned_s     = is_word_aligned(sel_addr_s[1:0]);
    assign unused_addr_s = ^{sel_addr_s[31:MEM_AW+2]};

    // RAM strobes appear in the accept cycle; address/data hold when idle.
    assign mem_we_o    = accept_s & sel_we_s & aligned_s;
    assign mem_addr_o  = accept_s ? sel_addr_s[MEM_AW+1:2] : addr_hold_r;
    assign mem_wdata_o = accept_s ? sel_wdata_s : wdata_hold_r;

    // Response pipeline and held RAM address/data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_hold_r  <= {MEM_AW{1'b0}};
            wdata_hold_r <= {DATA_W{1'b0}};
            rvalid_r     <= 2'b00;
            err_r        <= 2'b00;
        end else begin
            if (accept_s) begin
                addr_hold_r  <= sel_addr_s[MEM_AW+1:2];
                wdata_hold_r <= sel_wdata_s;
            end else begin
                addr_hold_r  <= addr_hold_r;
                wdata_hold_r <= wdata_hold_r;
            end
            rvalid_r <= {accept_s & (sel_s == M1_IDX) & ~sel_we_s,
                         accept_s & (sel_s == M0_IDX) & ~sel_we_s};
            err_r    <= {accept_s & (sel_s == M1_IDX) & ~aligned_s,
                         accept_s & (sel_s == M0_IDX) & ~aligned_s};
        end
    end

    // A response whose cycle coincides with reset is dropped.
    assign rvalid_s = rvalid_r & {2{~rst_i}};
    assign err_s    = err_r & {2{~rst_i}};

    assign m0_rvalid_o = rvalid_s[M0_IDX];
    assign m1_rvalid_o = rvalid_s[M1_IDX];
    assign m0_err_o    = err_s[M0_IDX];
    assign m1_err_o    = err_s[M1_IDX];

    // Misaligned reads return zero instead of whatever the RAM drives.
    assign m0_rdata_o = (rvalid_s[M0_IDX] && !err_r[M0_IDX]) ? mem_rdata_i : {DATA_W{1'b0}};
    assign m1_rdata_o = (rvalid_s[M1_IDX] && !err_r[M1_IDX]) ? mem_rdata_i : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_arbiter
// Scoreboard bench for dram_arbiter. A stimulus process drives one cycle at a
// time, evaluates a behavioural model of the arbitration rules and pushes the
// expected grant/RAM view and the expected read/error responses into queues.
// An independent monitor samples the DUT just after each falling edge and
// compares against the queue heads.
// -----------------------------------------------------------------------------
module tb_dram_arbiter;

    localparam int MEM_AW   = 14;
    localparam int MAX_LOCK = 16;
    localparam int N_RAND   = 1500;
    localparam int TAB_N    = 4096;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              m0_req_i = 1'b0, m0_we_i = 1'b0, m0_lock_i = 1'b0;
    logic [31:0]       m0_addr_i = 32'h0, m0_wdata_i = 32'h0;
    logic              m1_req_i = 1'b0, m1_we_i = 1'b0, m1_lock_i = 1'b0;
    logic [31:0]       m1_addr_i = 32'h0, m1_wdata_i = 32'h0;
    logic [31:0]       mem_rdata_i = 32'h0;
    logic              m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic              m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0]       m0_rdata_o, m1_rdata_o, mem_wdata_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic              mem_we_o;

    always #5 clk = ~clk;

    dram_arbiter #(.MEM_AW(MEM_AW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_lock_i(m0_lock_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        int                cyc;
        logic [1:0]        gnt;
        logic              we;
        logic              chk_hold;
        logic [MEM_AW-1:0] addr;
        logic [31:0]       wdata;
    } acc_t;

    typedef struct {
        int          due;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    acc_t        acc_q[$];
    rsp_t        rsp_q0[$];
    rsp_t        rsp_q1[$];
    logic [31:0] rdata_tab [0:TAB_N-1];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: -1 = nobody owns the RAM, otherwise owning master.
    int                m_owner = -1;
    int                m_last  = 1;
    int                m_hold  = 0;
    bit                m_blocked [2];
    logic [MEM_AW-1:0] m_addr  = '0;
    logic [31:0]       m_wdata = 32'h0;
    int                lock_left [2];

    task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, c, act, exp);
        end
    endtask

    // One bus cycle: drive inputs at the falling edge and predict the outcome.
    task automatic drive(input logic rst, input logic [1:0] req, input logic [1:0] we,
                         input logic [1:0] lock, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        acc_t        a;
        rsp_t        r;
        int          g;
        int          o;
        logic [31:0] ad;
        logic        wr;
        logic        al;
        @(negedge clk);
        rst_i = rst;
        m0_req_i = req[0]; m0_we_i = we[0]; m0_lock_i = lock[0]; m0_addr_i = a0; m0_wdata_i = d0;
        m1_req_i = req[1]; m1_we_i = we[1]; m1_lock_i = lock[1]; m1_addr_i = a1; m1_wdata_i = d1;
        mem_rdata_i = rdata_tab[cyc];

        g = -1;
        if (!rst) begin
            if (m_owner < 0) begin
                if (req == 2'b11) g = 1 - m_last;
                else if (req[0]) g = 0;
                else if (req[1]) g = 1;
            end else if (req[m_owner]) begin
                g = m_owner;
            end
        end

        a.cyc = cyc;
        a.gnt = (g == 0) ? 2'b01 : ((g == 1) ? 2'b10 : 2'b00);
        a.we  = 1'b0;
        a.chk_hold = !rst;
        if (g >= 0) begin
            ad = (g == 1) ? a1 : a0;
            wr = we[g];
            al = (ad[1:0] == 2'b00);
            a.we    = wr && al;
            m_addr  = ad[MEM_AW+1:2];
            m_wdata = (g == 1) ? d1 : d0;
            if (!wr || !al) begin
                r.due   = cyc + 1;
                r.rv    = !wr;
                r.err   = !al;
                r.rdata = al ? rdata_tab[cyc+1] : 32'h0;
                if (g == 0) rsp_q0.push_back(r); else rsp_q1.push_back(r);
            end
        end
        a.addr  = m_addr;
        a.wdata = m_wdata;
        acc_q.push_back(a);

        if (rst) begin
            // Responses due in a reset cycle must not appear.
            while (rsp_q0.size() > 0 && rsp_q0[$].due == cyc) void'(rsp_q0.pop_back());
            while (rsp_q1.size() > 0 && rsp_q1[$].due == cyc) void'(rsp_q1.pop_back());
            m_owner = -1; m_last = 1; m_hold = 0;
            m_blocked[0] = 1'b0; m_blocked[1] = 1'b0;
            m_addr = '0; m_wdata = 32'h0;
        end else begin
            if (m_owner < 0) begin
                if (g >= 0) begin
                    m_last = g;
                    if (lock[g] && !m_blocked[g]) begin
                        m_owner = g;
                        m_hold  = 0;
                    end
                end
            end else begin
                o = m_owner;
                if (g >= 0) m_last = g;
                if (!lock[o]) begin
                    m_owner = -1;
                end else if (m_hold == MAX_LOCK - 1) begin
                    m_owner = -1;
                    m_blocked[o] = 1'b1;
                    m_last = o;
                end else begin
                    m_hold++;
                end
            end
            for (int m = 0; m < 2; m++) if (!lock[m]) m_blocked[m] = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    // Monitor: compare the DUT view against the scoreboard each cycle.
    initial begin
        acc_t        a;
        rsp_t        e;
        logic        rv;
        logic        er;
        logic [31:0] rd;
        bit          have;
        forever begin
            @(negedge clk);
            #1;
            if (acc_q.size() > 0) begin
                a = acc_q.pop_front();
                check("gnt", a.cyc, 32'({m1_gnt_o, m0_gnt_o}), 32'(a.gnt));
                check("mem_we", a.cyc, 32'(mem_we_o), 32'(a.we));
                if (a.chk_hold) begin
                    check("mem_addr", a.cyc, 32'(mem_addr_o), 32'(a.addr));
                    check("mem_wdata", a.cyc, mem_wdata_o, a.wdata);
                end
                for (int m = 0; m < 2; m++) begin
                    rv   = (m == 1) ? m1_rvalid_o : m0_rvalid_o;
                    er   = (m == 1) ? m1_err_o    : m0_err_o;
                    rd   = (m == 1) ? m1_rdata_o  : m0_rdata_o;
                    have = (m == 1) ? (rsp_q1.size() > 0) : (rsp_q0.size() > 0);
                    if (have) e = (m == 1) ? rsp_q1[0] : rsp_q0[0];
                    if (rv || er) begin
                        if (!have) begin
                            check($sformatf("m%0d_unexpected_rsp", m), a.cyc, 32'({rv, er}), 32'h0);
                        end else begin
                            if (m == 1) void'(rsp_q1.pop_front()); else void'(rsp_q0.pop_front());
                            check($sformatf("m%0d_rsp_cycle", m), a.cyc, 32'(a.cyc), 32'(e.due));
                            check($sformatf("m%0d_rvalid", m), a.cyc, 32'(rv), 32'(e.rv));
                            check($sformatf("m%0d_err", m), a.cyc, 32'(er), 32'(e.err));
                            if (e.rv) check($sformatf("m%0d_rdata", m), a.cyc, rd, e.rdata);
                        end
                    end else if (have && e.due <= a.cyc) begin
                        if (m == 1) void'(rsp_q1.pop_front()); else void'(rsp_q0.pop_front());
                        check($sformatf("m%0d_missing_rsp", m), a.cyc, 32'({rv, er}), 32'({e.rv, e.err}));
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic [1:0]  rq;
        logic [1:0]  wv;
        logic [1:0]  lk;
        logic [31:0] ad [2];
        logic [31:0] dt [2];
        logic        rr;

        for (int i = 0; i < TAB_N; i++) rdata_tab[i] = $urandom;
        lock_left[0] = 0;
        lock_left[1] = 0;

        drive(1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

        // Single aligned read by m0 returning DEADBEEF.
        rdata_tab[cyc+1] = 32'hDEAD_BEEF;
        drive(1'b0, 2'b01, 2'b00, 2'b00, 32'h0000_0010, 32'h0, 32'h0, 32'h0);
        idle_cycle();

        // Misaligned write then misaligned read.
        drive(1'b0, 2'b01, 2'b01, 2'b00, 32'h0000_0006, 32'h0, 32'h1234_5678, 32'h0);
        drive(1'b0, 2'b01, 2'b00, 2'b00, 32'h0000_0003, 32'h0, 32'h0, 32'h0);
        idle_cycle();

        // Reset right after an accepted read, then tied reads alternate.
        drive(1'b0, 2'b01, 2'b00, 2'b00, 32'h0000_0040, 32'h0, 32'h0, 32'h0);
        drive(1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++)
            drive(1'b0, 2'b11, 2'b00, 2'b00, 32'h100 + 32'(4*k), 32'h200 + 32'(4*k), 32'h0, 32'h0);

        // m1 locked write burst against a requesting m0.
        for (int k = 0; k < 7; k++)
            drive(1'b0, 2'b11, 2'b10, (k < 5) ? 2'b10 : 2'b00,
                  32'h300, 32'h400 + 32'(4*k), 32'h0, 32'hA5A5_0000 + 32'(k));

        // m1 holds lock well past MAX_LOCK: forced release, then no re-own.
        for (int k = 0; k < 26; k++)
            drive(1'b0, 2'b11, 2'b00, (k < 22) ? 2'b10 : 2'b00,
                  32'h500 + 32'(4*k), 32'h600 + 32'(4*k), 32'h0, 32'h0);
        idle_cycle();

        for (int i = 0; i < N_RAND; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (lock_left[m] == 0 && $urandom_range(0, 9) == 0)
                    lock_left[m] = int'($urandom_range(1, 24));
                lk[m] = (lock_left[m] > 0);
                if (lock_left[m] > 0) lock_left[m]--;
                rq[m] = ($urandom_range(0, 9) < 7);
                wv[m] = ($urandom_range(0, 1) == 1);
                ad[m] = $urandom;
                if ($urandom_range(0, 7) != 0) ad[m][1:0] = 2'b00;
                dt[m] = $urandom;
            end
            rr = ($urandom_range(0, 149) == 0);
            drive(rr, rq, wv, lk, ad[0], ad[1], dt[0], dt[1]);
        end

        for (int k = 0; k < 4; k++) idle_cycle();
        @(negedge clk);
        #3;
        check("m0_rsp_left", cyc, 32'(rsp_q0.size()), 32'h0);
        check("m1_rsp_left", cyc, 32'(rsp_q1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter MEM_AW, default 14: word-address width of the shared data RAM.
REQ-002 Parameter MAX_LOCK, default 16: maximum consecutive cycles one master may hold a lock.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 m{0,1}_req_i  input  1  access request from master 0 (CPU) / master 1 (debug loader).
REQ-006 m{0,1}_we_i  input  1  1 = write, 0 = read.
REQ-007 m{0,1}_lock_i  input  1  request exclusive ownership after the current access.
REQ-008 m{0,1}_addr_i  input  32  byte address.
REQ-009 m{0,1}_wdata_i  input  32  write data.
REQ-010 m{0,1}_gnt_o  output  1  combinational; access accepted this cycle when req and gnt are both high.
REQ-011 m{0,1}_rvalid_o  output  1  read response valid, one-cycle pulse.
REQ-012 m{0,1}_rdata_o  output  32  read data, meaningful only while rvalid is high.
REQ-013 m{0,1}_err_o  output  1  one-cycle pulse flagging a misaligned accepted access.
REQ-014 mem_addr_o  output  MEM_AW  word address, equal to accepted addr[MEM_AW+1:2].
REQ-015 mem_we_o  output  1  RAM write strobe.
REQ-016 mem_wdata_o  output  32  RAM write data.
REQ-017 mem_rdata_i  input  32  RAM read data, valid the cycle after its address.

Function
REQ-018 At most one master SHALL be granted per cycle; gnt is never high without the matching req.
REQ-019 States: IDLE, OWN0, OWN1.
REQ-020 In IDLE, a single requester SHALL be granted; if both request, grant the master that is not last_grant.
REQ-021 last_grant SHALL update to the accepted master on every accepted access.
REQ-022 Accepted access with lock_x=1 in IDLE, and blocked_x=0: next state SHALL be OWNx and the hold counter SHALL clear to 0.
REQ-023 In OWNx: gnt_x=req_x, the other master's gnt=0, and the hold counter increments each cycle.
REQ-024 OWNx SHALL exit to IDLE next cycle when lock_x is sampled low.
REQ-025 OWNx SHALL also exit to IDLE next cycle when the counter equals MAX_LOCK-1 with lock_x still high; on this forced exit set blocked_x and last_grant=x.
REQ-026 blocked_x SHALL clear when lock_x is sampled low; while set, lock_x is ignored.
REQ-027 Aligned accepted write (addr[1:0]=0): mem_we_o=1 in the same cycle; writes produce no response.
REQ-028 Aligned accepted read: mem_we_o=0; on the next cycle, rvalid of that master is 1 and its rdata equals mem_rdata_i.
REQ-029 Misaligned accepted access: mem_we_o held 0; err_o pulses next cycle; a misaligned read also pulses rvalid with rdata=0.
REQ-030 With no access accepted: mem_we_o=0, and mem_addr_o/mem_wdata_o hold their last values.
REQ-031 Back-to-back accepted reads SHALL sustain one response per cycle with no bubble.

Reset
REQ-032 During rst_i: state=IDLE, last_grant=1, blocked_0=blocked_1=0, counter=0; all registered outputs=0.
REQ-033 A read accepted in the cycle before reset SHALL produce no rvalid.

Structure
REQ-034 Shared package SHALL hold the state enum (IDLE/OWN0/OWN1), DATA_W=32 and master-index constants.
REQ-035 The round-robin/lock FSM SHALL be sub-module arb_rr_lock (inputs: reqs, locks; outputs: grant vector, owner).
REQ-036 The response pipeline register and address/data mux SHALL remain in dram_arbiter.

Verification
REQ-037 Reset, then m0 reads 0x0000_0010 with mem_rdata_i=0xDEADBEEF -> m0_gnt_o=1 and mem_addr_o=0x004 same cycle; m0_rvalid_o=1 with 0xDEADBEEF next cycle.
REQ-038 Both masters issue continuous reads for 4 cycles from reset -> grants m0,m1,m0,m1; rvalid alternates, one cycle late.
REQ-039 m1 issues a locked 4-write burst while m0 requests -> m0_gnt_o=0 during the burst; m0 is granted the cycle after m1 enters IDLE.
REQ-040 m1 holds lock for 20 cycles with MAX_LOCK=16 while m0 requests -> forced release; m0 granted next; m1 cannot re-own until lock drops.
REQ-041 m0 writes 0x0000_0006 -> m0_gnt_o=1, mem_we_o=0, m0_err_o pulses; m0 reads 0x0000_0003 -> rvalid with rdata=0 and err.
REQ-042 rst_i asserted the cycle after an accepted read -> no rvalid; FSM in IDLE; a tie then grants m0 first.
